// File: rtl/ysyx_22050550_pcgen_pkg.sv
// Shared definitions for the fetch PC generator: defaults and FSM state encoding.
package ysyx_22050550_pcgen_pkg;
  localparam int unsigned ysyx_22050550_XLEN    = 32;
  localparam logic [31:0] ysyx_22050550_RESET_PC = 32'h8000_0000;
  localparam int unsigned ysyx_22050550_InstBus = 4;
  localparam int unsigned ysyx_22050550_EPOCH_W = 2;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pcgen_state_e;
endpackage

// File: rtl/ysyx_22050550_pcgen_if.sv
// Fetch-request handshake between the PC generator (master) and the IFU (slave).
interface ysyx_22050550_pcgen_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned EPOCH_W = 2
);
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_pc;
  logic [EPOCH_W-1:0] out_epoch;

  modport master (output out_valid, out_pc, out_epoch, input  out_ready);
  modport slave  (input  out_valid, out_pc, out_epoch, output out_ready);
endinterface

// File: rtl/ysyx_22050550_pcgen_redir_sel.sv
// Redirect priority mux (exception > mret > branch) with target alignment.
module ysyx_22050550_pcgen_redir_sel #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned INST_BYTES = 4
) (
  input  logic            exc_valid,
  input  logic [XLEN-1:0] exc_pc,
  input  logic            mret_valid,
  input  logic [XLEN-1:0] mret_pc,
  input  logic            br_valid,
  input  logic [XLEN-1:0] br_pc,
  output logic            redir,
  output logic [XLEN-1:0] tgt
);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INST_BYTES - 1));

  logic [XLEN-1:0] sel_pc;

  always_comb begin
    sel_pc = br_pc;
    if (exc_valid)       sel_pc = exc_pc;
    else if (mret_valid) sel_pc = mret_pc;
  end

  assign redir = exc_valid | mret_valid | br_valid;
  assign tgt   = sel_pc & ALIGN_MASK;
endmodule

// File: rtl/ysyx_22050550_pcgen.sv
// Fetch PC generator: sequential/redirect next-PC, stall-time redirect buffering,
// epoch tagging of each request and a sticky halt.
module ysyx_22050550_pcgen
  import ysyx_22050550_pcgen_pkg::*;
#(
  parameter int unsigned     XLEN       = ysyx_22050550_XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(ysyx_22050550_RESET_PC),
  parameter int unsigned     INST_BYTES = ysyx_22050550_InstBus,
  parameter int unsigned     EPOCH_W    = ysyx_22050550_EPOCH_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                exc_valid,
  input  logic [XLEN-1:0]     exc_pc,
  input  logic                mret_valid,
  input  logic [XLEN-1:0]     mret_pc,
  input  logic                br_valid,
  input  logic [XLEN-1:0]     br_pc,
  input  logic                halt,
  ysyx_22050550_pcgen_if.master fetch,
  output logic [EPOCH_W-1:0]  cur_epoch,
  output logic                halted
);
  pcgen_state_e       state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d, pend_pc_q, pend_pc_d;
  logic               pend_valid_q, pend_valid_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d, out_epoch_q, out_epoch_d;
  logic               halt_req_q, halt_req_d;
  logic               out_valid_q, out_valid_d;
  logic               halted_q, halted_d;
  logic               redir, fire, halt_now;
  logic [XLEN-1:0]    tgt;
  logic [EPOCH_W-1:0] epoch_inc;

  ysyx_22050550_pcgen_redir_sel #(.XLEN(XLEN), .INST_BYTES(INST_BYTES)) u_redir_sel (
    .exc_valid (exc_valid),
    .exc_pc    (exc_pc),
    .mret_valid(mret_valid),
    .mret_pc   (mret_pc),
    .br_valid  (br_valid),
    .br_pc     (br_pc),
    .redir     (redir),
    .tgt       (tgt)
  );

  assign fire      = out_valid_q & fetch.out_ready;
  assign halt_now  = halt | halt_req_q;
  assign epoch_inc = epoch_q + EPOCH_W'(1);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    epoch_d      = epoch_q;
    out_epoch_d  = out_epoch_q;
    halt_req_d   = halt_req_q;
    unique case (state_q)
      ST_BOOT: begin
        // A redirect seen before the first request becomes that request.
        if (redir) begin
          pc_d        = tgt;
          epoch_d     = epoch_inc;
          out_epoch_d = epoch_inc;
        end
        halt_req_d = halt_now;
        state_d    = halt_now ? ST_HALT : ST_RUN;
      end
      ST_RUN: begin
        if (redir) epoch_d = epoch_inc;
        if (fire) begin
          pend_valid_d = 1'b0;
          if (redir) begin
            pc_d        = tgt;
            out_epoch_d = epoch_inc;
          end else if (pend_valid_q) begin
            pc_d        = pend_pc_q;
            out_epoch_d = epoch_q;
          end else begin
            pc_d        = pc_q + XLEN'(INST_BYTES);
            out_epoch_d = epoch_q;
          end
        end else if (redir) begin
          // Request is stalled: park the newest target until it is accepted.
          pend_valid_d = 1'b1;
          pend_pc_d    = tgt;
        end
        halt_req_d = halt_now;
        if (halt_now && fire) state_d = ST_HALT;
      end
      default: state_d = ST_HALT;
    endcase
    out_valid_d = (state_d == ST_RUN);
    halted_d    = (state_d == ST_HALT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
      epoch_q      <= '0;
      out_epoch_q  <= '0;
      halt_req_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      epoch_q      <= epoch_d;
      out_epoch_q  <= out_epoch_d;
      halt_req_q   <= halt_req_d;
      out_valid_q  <= out_valid_d;
      halted_q     <= halted_d;
    end
  end

  assign fetch.out_valid = out_valid_q;
  assign fetch.out_pc    = pc_q;
  assign fetch.out_epoch = out_epoch_q;
  assign cur_epoch       = epoch_q;
  assign halted          = halted_q;
endmodule

// File: tb/tb_ysyx_22050550_pcgen.sv
// Directed vector table, halt/reset sequences and randomized run against a behavioural model.
module tb_ysyx_22050550_pcgen;
  logic        clk, rst;
  logic        exc_valid, mret_valid, br_valid, halt;
  logic [31:0] exc_pc, mret_pc, br_pc;
  logic [1:0]  cur_epoch;
  logic        halted;

  ysyx_22050550_pcgen_if #(.XLEN(32), .EPOCH_W(2)) fif ();

  ysyx_22050550_pcgen dut (
    .clk(clk), .rst(rst),
    .exc_valid(exc_valid), .exc_pc(exc_pc),
    .mret_valid(mret_valid), .mret_pc(mret_pc),
    .br_valid(br_valid), .br_pc(br_pc),
    .halt(halt), .fetch(fif.master),
    .cur_epoch(cur_epoch), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural reference: what the fetch port should show after each edge.
  bit          m_valid, m_halted, m_halt_req, m_pend;
  int unsigned m_pc, m_pend_pc, m_epoch, m_oep;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_halted = 0; m_halt_req = 0; m_pend = 0;
    m_pc = 32'h8000_0000; m_pend_pc = 0; m_epoch = 0; m_oep = 0;
  endtask

  task automatic model_step();
    bit          redir, fire, hnow;
    int unsigned tgt;
    if (m_halted) return;
    redir = exc_valid | mret_valid | br_valid;
    tgt   = exc_valid ? exc_pc : (mret_valid ? mret_pc : br_pc);
    tgt   = tgt - (tgt % 4);
    hnow  = halt | m_halt_req;
    fire  = m_valid & fif.out_ready;
    if (!m_valid) begin
      if (redir) begin m_pc = tgt; m_oep = (m_epoch + 1) % 4; end
      if (hnow) m_halted = 1; else m_valid = 1;
    end else begin
      if (fire) begin
        if (redir)       begin m_pc = tgt;       m_oep = (m_epoch + 1) % 4; end
        else if (m_pend) begin m_pc = m_pend_pc; m_oep = m_epoch; end
        else             begin m_pc = m_pc + 4;  m_oep = m_epoch; end
        m_pend = 0;
      end else if (redir) begin
        m_pend = 1; m_pend_pc = tgt;
      end
      if (hnow && fire) begin m_valid = 0; m_halted = 1; end
    end
    m_halt_req = hnow;
    if (redir) m_epoch = (m_epoch + 1) % 4;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".valid"},  fif.out_valid, m_valid);
    check({tag, ".pc"},     fif.out_pc,    m_pc);
    check({tag, ".oep"},    fif.out_epoch, m_oep[1:0]);
    check({tag, ".cep"},    cur_epoch,     m_epoch[1:0]);
    check({tag, ".halted"}, halted,        m_halted);
  endtask

  task automatic clear_in();
    exc_valid = 0; mret_valid = 0; br_valid = 0; halt = 0;
    exc_pc = 0; mret_pc = 0; br_pc = 0;
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk); #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    clear_in(); fif.out_ready = 1;
    rst = 0; model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst.valid", fif.out_valid, 1'b0);
    check("rst.pc", fif.out_pc, 32'h8000_0000);
    check("rst.cep", cur_epoch, 2'd0);
    check("rst.halted", halted, 1'b0);
    rst = 1;
  endtask

  typedef struct {
    logic        rdy;
    logic        exv;  logic [31:0] exp;
    logic        mv;   logic [31:0] mp;
    logic        bv;   logic [31:0] bp;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [1:0]  e_oep, e_cep;
  } vec_t;

  vec_t vec[15];

  initial begin
    // rdy  exc               mret              br                 exp: valid pc          oep cep
    vec[0]  = '{1, 0, 0,            0, 0,            0, 0,            1, 32'h8000_0000, 0, 0};
    vec[1]  = '{1, 0, 0,            0, 0,            0, 0,            1, 32'h8000_0004, 0, 0};
    vec[2]  = '{0, 0, 0,            0, 0,            1, 32'h8000_0100, 1, 32'h8000_0004, 0, 1};
    vec[3]  = '{0, 0, 0,            0, 0,            0, 0,            1, 32'h8000_0004, 0, 1};
    vec[4]  = '{0, 0, 0,            0, 0,            0, 0,            1, 32'h8000_0004, 0, 1};
    vec[5]  = '{1, 0, 0,            0, 0,            0, 0,            1, 32'h8000_0100, 1, 1};
    vec[6]  = '{1, 1, 32'h8000_0200, 1, 32'h8000_0300, 1, 32'h8000_0400, 1, 32'h8000_0200, 2, 2};
    vec[7]  = '{1, 0, 0,            0, 0,            1, 32'h8000_0102, 1, 32'h8000_0100, 3, 3};
    vec[8]  = '{0, 0, 0,            0, 0,            1, 32'h8000_0100, 1, 32'h8000_0100, 3, 0};
    vec[9]  = '{0, 0, 0,            0, 0,            1, 32'h8000_0500, 1, 32'h8000_0100, 3, 1};
    vec[10] = '{1, 0, 0,            0, 0,            0, 0,            1, 32'h8000_0500, 1, 1};
    vec[11] = '{1, 0, 0,            0, 0,            0, 0,            1, 32'h8000_0504, 1, 1};
    vec[12] = '{1, 0, 0,            1, 32'h8000_0303, 0, 0,            1, 32'h8000_0300, 2, 2};
    vec[13] = '{1, 0, 0,            0, 0,            1, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFC, 3, 3};
    vec[14] = '{1, 0, 0,            0, 0,            0, 0,            1, 32'h0000_0000, 3, 3};

    clear_in(); fif.out_ready = 1; rst = 0;
    #3;
    do_reset();

    foreach (vec[i]) begin
      fif.out_ready = vec[i].rdy;
      exc_valid = vec[i].exv; exc_pc  = vec[i].exp;
      mret_valid = vec[i].mv; mret_pc = vec[i].mp;
      br_valid  = vec[i].bv;  br_pc   = vec[i].bp;
      cycle($sformatf("vec%0d", i));
      check($sformatf("vec%0d.valid", i), fif.out_valid, vec[i].e_valid);
      check($sformatf("vec%0d.pc", i),    fif.out_pc,    vec[i].e_pc);
      check($sformatf("vec%0d.oep", i),   fif.out_epoch, vec[i].e_oep);
      check($sformatf("vec%0d.cep", i),   cur_epoch,     vec[i].e_cep);
    end
    clear_in();

    // Halt raised while stalled: the outstanding request must still be offered.
    fif.out_ready = 0; halt = 1;
    cycle("halt0");
    check("halt0.valid", fif.out_valid, 1'b1);
    check("halt0.pc", fif.out_pc, 32'h0);
    halt = 0;
    cycle("halt1");
    check("halt1.valid", fif.out_valid, 1'b1);
    fif.out_ready = 1;
    cycle("halt2");
    check("halt2.valid", fif.out_valid, 1'b0);
    check("halt2.halted", halted, 1'b1);
    br_valid = 1; br_pc = 32'h8000_0800;
    cycle("halt3");
    check("halt3.cep", cur_epoch, 2'd3);
    check("halt3.valid", fif.out_valid, 1'b0);
    clear_in();

    // Asynchronous reset between edges must act immediately.
    do_reset();
    repeat (3) cycle("pre_arst");
    #2 rst = 0; #1;
    check("arst.pc", fif.out_pc, 32'h8000_0000);
    check("arst.valid", fif.out_valid, 1'b0);
    check("arst.cep", cur_epoch, 2'd0);
    @(posedge clk); #1;

    // Randomized traffic, with an occasional halt, from several resets.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int c = 0; c < 200; c++) begin
        fif.out_ready = ($urandom_range(9) < 7);
        exc_valid  = ($urandom_range(19) == 0); exc_pc  = $urandom;
        mret_valid = ($urandom_range(19) == 0); mret_pc = $urandom;
        br_valid   = ($urandom_range(5) == 0);  br_pc   = $urandom;
        halt       = ($urandom_range(149) == 0);
        cycle("rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ysyx_22050550_pcgen.md
Name: ysyx_22050550_pcgen

Overview:
Parametrised PC generator that replaces the plain enable-gated PC register ahead of the IFU. It holds the architectural fetch PC and presents it to fetch over a valid/ready handshake. It selects among sequential, branch, mret and exception targets, buffers redirects that arrive while a request is stalled, and tags each PC with an epoch so downstream stages can drop stale fetches.

Parameters:
XLEN, 32, PC/target width
RESET_PC, 32'h8000_0000, PC value loaded at reset
INST_BYTES, 4, sequential increment; targets forced aligned to this (power of 2)
EPOCH_W, 2, epoch counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
exc_valid  in  1  exception/trap redirect request
exc_pc  in  XLEN  trap target (mtvec)
mret_valid  in  1  mret redirect request
mret_pc  in  XLEN  return target (mepc)
br_valid  in  1  branch/jump redirect from EXU
br_pc  in  XLEN  branch/jump target
halt  in  1  stop fetch (ebreak/trap-to-sim), sticky
out_valid  out  1  fetch request valid
out_ready  in  1  IFU accepts request
out_pc  out  XLEN  PC of request
out_epoch  out  EPOCH_W  epoch tag of out_pc
cur_epoch  out  EPOCH_W  current epoch; IFU/IDU drop instructions whose tag differs
halted  out  1  block is in HALT

Behaviour:
- Reset (rst=0, asynchronous): pc=RESET_PC, state=BOOT, out_valid=0, pend_valid=0, pend_pc=0, epoch=0, out_epoch=0, halt_req=0, halted=0.
- States: BOOT -> RUN on the first clock after reset release. In RUN, out_valid=1. HALT: out_valid=0, halted=1, absorbing until reset.
- Handshake: fire = out_valid & out_ready. While out_valid=1 and fire=0, out_pc and out_epoch must remain stable.
- Redirect select, same cycle: exc > mret > br. redir = any valid. tgt = selected pc with low log2(INST_BYTES) bits cleared.
- Epoch: every cycle with redir=1 (outside HALT) increments epoch on the next edge, wrapping mod 2^EPOCH_W. cur_epoch = epoch register. Multiple redirects in consecutive cycles increment once each.
- Next-PC rules in RUN, evaluated at each edge:
  - fire & redir: pc<=tgt; out_epoch<=epoch+1; pend cleared.
  - fire & !redir & pend_valid: pc<=pend_pc; out_epoch<=epoch; pend cleared.
  - fire & neither: pc<=pc+INST_BYTES, wrapping mod 2^XLEN; out_epoch<=epoch.
  - !fire & redir: pc held; pend_valid<=1; pend_pc<=tgt. A newer redirect overwrites the pending one.
  - !fire & !redir: everything held.
- BOOT with redir: pc<=tgt and epoch increments, so the first request uses the target.
- halt=1 sets halt_req. The transition to HALT occurs at the first edge where fire=1 or out_valid=0, after the current request is accepted. Redirects are ignored once in HALT. If halt and redir occur in the same cycle, the redirect is still recorded, then HALT is entered.
- No combinational path from out_ready or redirect inputs to out_valid or out_pc. All outputs are registered.

Decomposition:
- Shared define file additions: ysyx_22050550_RESET_PC, ysyx_22050550_InstBus width, epoch width, state encoding localparams (BOOT/RUN/HALT).
- One natural sub-module: ysyx_22050550_redir_sel, a combinational priority mux plus alignment producing redir/tgt.
- PC, pend and epoch registers are instances of the existing ysyx_22050550_Reg with their reset values.

Test Plan:
- Reset, out_ready=1, no redirects -> cycle1 out_valid=0; then out_pc 0x80000000, 0x80000004, 0x80000008 on consecutive cycles; out_epoch=0.
- out_ready=0 for 3 cycles with br_valid=1, br_pc=0x80000100 in cycle 1 -> out_pc stays 0x80000004 (stable); cur_epoch=1; after out_ready=1 fires, next out_pc=0x80000100, out_epoch=1.
- Same cycle exc_valid (0x80000200), mret_valid (0x80000300), br_valid (0x80000400) with fire -> next out_pc=0x80000200.
- br_pc=0x80000102 -> out_pc=0x80000100 (aligned).
- Redirects in two consecutive stalled cycles (0x80000100, then 0x80000500) -> cur_epoch +2; after fire, out_pc=0x80000500.
- halt=1 while stalled -> out_valid stays 1 until out_ready; next cycle out_valid=0, halted=1; later br_valid ignored. Async rst=0 mid-run -> immediate RESET_PC, out_valid=0.
